// File: rtl/gray_pkg.sv
// Binary/Gray conversion helpers shared by the Gray counter.
// Functions operate on a 16-bit container; only the low `width` bits are meaningful.
package gray_pkg;

  localparam int MAX_WIDTH = 16;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(
    input logic [MAX_WIDTH-1:0] b,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) mask[i] = 1'b1;
    end
    return (b ^ (b >> 1)) & mask;
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it, so scan from the MSB down.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(
    input logic [MAX_WIDTH-1:0] g,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] b;
    logic                 acc;
    b   = '0;
    acc = 1'b0;
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      if (i < width) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_updown_counter.sv
// Up/down counter holding a binary register and a Gray register in lockstep,
// so Q comes straight from a flop and every count step flips exactly one bit.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] bin,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;

  // Priority: load, then enabled count, otherwise hold.
  always_comb begin
    b_d = b_q;
    if (load) begin
      b_d = WIDTH'(gray2bin(MAX_WIDTH'(load_val), WIDTH));
    end else if (en) begin
      if (up) begin
        if (b_q == MAX_VAL) b_d = WRAP ? '0 : b_q;
        else                b_d = b_q + ONE;
      end else begin
        if (b_q == '0) b_d = WRAP ? MAX_VAL : b_q;
        else           b_d = b_q - ONE;
      end
    end
    g_d = WIDTH'(bin2gray(MAX_WIDTH'(b_d), WIDTH));
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      b_q <= '0;
      g_q <= '0;
    end else begin
      b_q <= b_d;
      g_q <= g_d;
    end
  end

  assign Q   = g_q;
  assign bin = b_q;
  assign tc  = up ? (b_q == MAX_VAL) : (b_q == '0);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench for gray_updown_counter: a wrapping and a saturating instance share
// the stimulus and are compared against an integer reference model.
module tb_gray_updown_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clock;
  logic         Reset;
  logic         en, up, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q_w, bin_w, q_s, bin_s;
  logic         tc_w, tc_s;

  int n_checks = 0;
  int n_fail   = 0;

  // {step_w, step_s, q_w, bin_w, tc_w, q_s, bin_s, tc_s}
  logic [19:0] exp_q[$];

  int           m_w, m_s;
  logic [W-1:0] last_w, last_s;

  gray_updown_counter #(.WIDTH(W), .WRAP(1'b1)) dut_w (
    .clock(clock), .Reset(Reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .Q(q_w), .bin(bin_w), .tc(tc_w)
  );

  gray_updown_counter #(.WIDTH(W), .WRAP(1'b0)) dut_s (
    .clock(clock), .Reset(Reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .Q(q_s), .bin(bin_s), .tc(tc_s)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: Gray code of n is n ^ (n >> 1); its inverse found by search
  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int g2b(input int g);
    for (int v = 0; v <= MAXV; v++) begin
      if (b2g(v) == g) return v;
    end
    return 0;
  endfunction

  function automatic int next_val(input int b, input bit e, input bit u, input bit l,
                                  input int lv, input bit wrap);
    if (l)  return g2b(lv);
    if (!e) return b;
    if (u)  return (b == MAXV) ? (wrap ? 0 : MAXV) : b + 1;
    return (b == 0) ? (wrap ? MAXV : 0) : b - 1;
  endfunction

  // driver: inputs change on the falling edge; expectation for the next rising edge is queued
  task automatic cycle(input bit e, input bit u, input bit l, input logic [W-1:0] lv);
    int           nw, ns;
    logic [W-1:0] gw, gs, bw, bs;
    logic         tw, ts, sw, ss;
    @(negedge clock);
    en = e; up = u; load = l; load_val = lv;
    nw = next_val(m_w, e, u, l, int'(lv), 1'b1);
    ns = next_val(m_s, e, u, l, int'(lv), 1'b0);
    gw = W'(b2g(nw)); bw = W'(nw); tw = u ? (nw == MAXV) : (nw == 0);
    gs = W'(b2g(ns)); bs = W'(ns); ts = u ? (ns == MAXV) : (ns == 0);
    sw = e && !l && (nw != m_w);
    ss = e && !l && (ns != m_s);
    exp_q.push_back({sw, ss, gw, bw, tw, gs, bs, ts});
    m_w = nw;
    m_s = ns;
  endtask

  // monitor: pops one expectation per rising edge, after outputs settle
  always @(posedge clock) begin
    logic [19:0] e;
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("q_wrap",   int'(q_w),   int'(e[17:14]));
      chk("bin_wrap", int'(bin_w), int'(e[13:10]));
      chk("tc_wrap",  int'(tc_w),  int'(e[9]));
      chk("q_sat",    int'(q_s),   int'(e[8:5]));
      chk("bin_sat",  int'(bin_s), int'(e[4:1]));
      chk("tc_sat",   int'(tc_s),  int'(e[0]));
      if (e[19]) chk("hamming_wrap", $countones(q_w ^ last_w), 1);
      if (e[18]) chk("hamming_sat",  $countones(q_s ^ last_s), 1);
      last_w = q_w;
      last_s = q_s;
    end
  end

  // asserts reset between edges and checks the immediate clear
  task automatic mid_reset();
    @(posedge clock);
    #4;
    en = 1'b0; load = 1'b0;
    Reset = 1'b0;
    #0.5;
    chk("rst_q_wrap",   int'(q_w),   0);
    chk("rst_bin_wrap", int'(bin_w), 0);
    chk("rst_q_sat",    int'(q_s),   0);
    chk("rst_bin_sat",  int'(bin_s), 0);
    chk("rst_tc_wrap",  int'(tc_w),  int'(!up));
    m_w = 0; m_s = 0; last_w = '0; last_s = '0;
    @(negedge clock);
    Reset = 1'b1;
  endtask

  logic [W-1:0] gray_tab [0:16];

  initial begin
    gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                 4'b0000};
    Reset = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
    m_w = 0; m_s = 0; last_w = '0; last_s = '0;
    #3;
    chk("init_q",     int'(q_w),   0);
    chk("init_bin",   int'(bin_w), 0);
    chk("init_tc_dn", int'(tc_w),  1);
    up = 1'b1;
    #1;
    chk("init_tc_up", int'(tc_w),  0);
    @(negedge clock);
    Reset = 1'b1;

    // full up sequence with wrap, against the literal Gray table
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      @(posedge clock);
      #4;
      chk("gray_table", int'(q_w), int'(gray_tab[i+1]));
    end
    // saturating instance sits at the top; three more enabled cycles, then step down
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // count to 0110 then reset between edges, restart from zero
    mid_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    mid_reset();
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // down from zero: tc before the edge, wrap to 1000 on it
    cycle(1'b1, 1'b0, 1'b0, '0);
    #1;
    chk("tc_before_wrap_down", int'(tc_w), 1);

    // load overrides en/up, then count continues from loaded value
    cycle(1'b1, 1'b1, 1'b1, 4'b1010);
    cycle(1'b1, 1'b1, 1'b0, '0);

    // hold with up toggling, at an endpoint and mid-range
    cycle(1'b0, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) cycle(1'b0, bit'(i % 2), 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 4'b0110);
    for (int i = 0; i < 5; i++) cycle(1'b0, bit'(i % 2), 1'b0, '0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, W'($urandom_range(0, MAXV)));
    end

    @(negedge clock);
    en = 1'b0; load = 1'b0;
    repeat (3) @(posedge clock);
    #4;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
